// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
// axi_slave_mem : AXI4 INCR-burst memory slave with independent write/read engines.
// Optional macro AXI_SLAVE_MEM_RD_WAIT_EN inserts READ_WAIT idle cycles before each read burst.
// Revision: 1.0
// ============================================================================
module axi_slave_mem #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ID_W      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
`ifdef AXI_SLAVE_MEM_RD_WAIT_EN
  ,
  parameter int unsigned READ_WAIT = 2
`endif
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [31:0]     AWADDR,
  input  logic [ID_W-1:0] AWID,
  input  logic [7:0]      AWLEN,
  input  logic            WVALID,
  output logic            WREADY,
  input  logic [31:0]     WDATA,
  input  logic            WLAST,
  output logic            BVALID,
  input  logic            BREADY,
  output logic [ID_W-1:0] BID,
  output logic [1:0]      BRESP,
  input  logic            ARVALID,
  output logic            ARREADY,
  input  logic [31:0]     ARADDR,
  input  logic [ID_W-1:0] ARID,
  input  logic [7:0]      ARLEN,
  output logic            RVALID,
  input  logic            RREADY,
  output logic [ID_W-1:0] RID,
  output logic [31:0]     RDATA,
  output logic [1:0]      RRESP,
  output logic            RLAST
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

`ifdef AXI_SLAVE_MEM_RD_WAIT_EN
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_DATA = 2'd1,
    R_WAIT = 2'd2
  } rstate_t;
  localparam logic [31:0] WAIT_LAST = 32'(READ_WAIT) - 32'd1;
`else
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_DATA = 2'd1
  } rstate_t;
`endif

  logic [31:0] mem [DEPTH];

  // Write engine state
  wstate_t         wstate_q, wstate_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [ID_W-1:0] wid_q, wid_d;
  logic [31:0]     widx_q, widx_d;
  logic [7:0]      wlen_q, wlen_d;
  logic [7:0]      wcnt_q, wcnt_d;
  logic            werr_q, werr_d;
  logic            mem_we;

  // Read engine state
  rstate_t         rstate_q, rstate_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            rlast_q, rlast_d;
  logic [ID_W-1:0] rlid_q, rlid_d;
  logic [31:0]     ridx_q, ridx_d;
  logic [7:0]      rlen_q, rlen_d;
  logic [7:0]      rcnt_q, rcnt_d;
  logic            rload;
  logic            rbeat_ok;
`ifdef AXI_SLAVE_MEM_RD_WAIT_EN
  logic [31:0]     wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    mem_we    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (AWVALID && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wid_d     = AWID;
          widx_d    = (AWADDR - BASE_ADDR) >> 2;
          wlen_d    = AWLEN;
          wcnt_d    = 8'd0;
          werr_d    = 1'b0;
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID && wready_q) begin
          if (widx_q < DEPTH_W) mem_we = 1'b1;
          else                  werr_d = 1'b1;
          if (WLAST != (wcnt_q == wlen_q)) werr_d = 1'b1;
          widx_d = widx_q + 32'd1;
          wcnt_d = wcnt_q + 8'd1;
          // Beat count, not WLAST, terminates the burst.
          if (wcnt_q == wlen_q) begin
            wready_d = 1'b0;
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (!bvalid_q) begin
          bvalid_d = 1'b1;
          bid_d    = wid_q;
          bresp_d  = werr_q ? 2'b10 : 2'b00;
        end else if (BREADY) begin
          bvalid_d  = 1'b0;
          bid_d     = '0;
          bresp_d   = 2'b00;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rlid_d    = rlid_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rload     = 1'b0;
    rbeat_ok  = (ridx_q < DEPTH_W);
`ifdef AXI_SLAVE_MEM_RD_WAIT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          arready_d = 1'b0;
          rlid_d    = ARID;
          ridx_d    = (ARADDR - BASE_ADDR) >> 2;
          rlen_d    = ARLEN;
          rcnt_d    = 8'd0;
          rstate_d  = R_DATA;
`ifdef AXI_SLAVE_MEM_RD_WAIT_EN
          wait_cnt_d = 32'd0;
          if (READ_WAIT != 0) rstate_d = R_WAIT;
`endif
        end
      end
`ifdef AXI_SLAVE_MEM_RD_WAIT_EN
      R_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) rstate_d = R_DATA;
        else                         wait_cnt_d = wait_cnt_q + 32'd1;
      end
`endif
      R_DATA: begin
        if (!rvalid_q) begin
          rload = 1'b1;
        end else if (RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rid_d     = '0;
            rdata_d   = 32'd0;
            rresp_d   = 2'b00;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
          end else begin
            rload = 1'b1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    if (rload) begin
      rvalid_d = 1'b1;
      rid_d    = rlid_q;
      rdata_d  = rbeat_ok ? mem[ridx_q[IDX_W-1:0]] : 32'd0;
      rresp_d  = rbeat_ok ? 2'b00 : 2'b10;
      rlast_d  = (rcnt_q == rlen_q);
      ridx_d   = ridx_q + 32'd1;
      rcnt_d   = rcnt_q + 8'd1;
    end
  end

  // Storage is never reset; writes are suppressed while ARESET holds the FSM idle.
  always_ff @(posedge ACLK) begin
    if (mem_we) mem[widx_q[IDX_W-1:0]] <= WDATA;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      wid_q     <= '0;
      widx_q    <= 32'd0;
      wlen_q    <= 8'd0;
      wcnt_q    <= 8'd0;
      werr_q    <= 1'b0;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      rlid_q    <= '0;
      ridx_q    <= 32'd0;
      rlen_q    <= 8'd0;
      rcnt_q    <= 8'd0;
`ifdef AXI_SLAVE_MEM_RD_WAIT_EN
      wait_cnt_q <= 32'd0;
`endif
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rlid_q    <= rlid_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
`ifdef AXI_SLAVE_MEM_RD_WAIT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// ============================================================================
// tb_axi_slave_mem : directed self-checking bench for axi_slave_mem.
// Revision: 1.0
// ============================================================================
module tb_axi_slave_mem;

`ifdef AXI_SLAVE_MEM_RD_WAIT_EN
  localparam int RD_EXTRA = 2;
  localparam logic [31:0] RBW_EXP = 32'h0000_2222;
`else
  localparam int RD_EXTRA = 0;
  localparam logic [31:0] RBW_EXP = 32'h0000_1111;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        AWVALID = 1'b0, AWREADY;
  logic [31:0] AWADDR = '0;
  logic [3:0]  AWID = '0;
  logic [7:0]  AWLEN = '0;
  logic        WVALID = 1'b0, WREADY;
  logic [31:0] WDATA = '0;
  logic        WLAST = 1'b0;
  logic        BVALID, BREADY = 1'b0;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        ARVALID = 1'b0, ARREADY;
  logic [31:0] ARADDR = '0;
  logic [3:0]  ARID = '0;
  logic [7:0]  ARLEN = '0;
  logic        RVALID, RREADY = 1'b0;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;

  axi_slave_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  logic [31:0] wd [8];
  logic [31:0] rd_data [8];
  logic [1:0]  rd_resp [8];
  logic        rd_last [8];
  logic [3:0]  rd_id [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    AWADDR = addr; AWID = id; AWLEN = len; AWVALID = 1'b1;
    while (!AWREADY && n < 20) begin tick(); n++; end
    if (n >= 20) check("aw_ready_timeout", 32'(AWREADY), 32'd1);
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    ARADDR = addr; ARID = id; ARLEN = len; ARVALID = 1'b1;
    while (!ARREADY && n < 20) begin tick(); n++; end
    if (n >= 20) check("ar_ready_timeout", 32'(ARREADY), 32'd1);
    tick();
    ARVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic last);
    int n = 0;
    WDATA = data; WLAST = last; WVALID = 1'b1;
    while (!WREADY && n < 20) begin tick(); n++; end
    if (n >= 20) check("w_ready_timeout", 32'(WREADY), 32'd1);
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    while (!BVALID && lat < 20) begin tick(); lat++; end
    if (lat >= 20) check("b_valid_timeout", 32'(BVALID), 32'd1);
  endtask

  task automatic wait_r(output int lat);
    lat = 0;
    while (!RVALID && lat < 20) begin tick(); lat++; end
    if (lat >= 20) check("r_valid_timeout", 32'(RVALID), 32'd1);
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [7:0] last_mask, output int lat,
                             output logic [3:0] bid, output logic [1:0] bresp);
    send_aw(addr, id, len);
    for (int i = 0; i <= int'(len); i++) send_w(wd[i], last_mask[i]);
    wait_b(lat);
    bid = BID; bresp = BRESP;
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            output int lat, output int gaps);
    int n;
    gaps = 0;
    RREADY = 1'b1;
    send_ar(addr, id, len);
    wait_r(lat);
    for (int i = 0; i <= int'(len); i++) begin
      if (i > 0) begin wait_r(n); gaps += n; end
      rd_data[i] = RDATA; rd_resp[i] = RRESP; rd_last[i] = RLAST; rd_id[i] = RID;
      tick();
    end
    RREADY = 1'b0;
  endtask

  initial begin
    int lat, gaps;
    logic [3:0] bid;
    logic [1:0] bresp;

    // Reset state; W offered before any AW must not be accepted
    WVALID = 1'b1; WDATA = 32'hDEAD_BEEF; WLAST = 1'b1;
    tick(); tick();
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_bvalid",  32'(BVALID),  32'd0);
    check("rst_rvalid",  32'(RVALID),  32'd0);
    check("rst_rdata",   RDATA,        32'd0);
    ARESET = 1'b0;
    check("rel_awready_before_edge", 32'(AWREADY), 32'd0);
    tick();
    check("rel_awready", 32'(AWREADY), 32'd1);
    check("rel_arready", 32'(ARREADY), 32'd1);
    tick();
    check("early_w_wready", 32'(WREADY), 32'd0);
    WVALID = 1'b0; WLAST = 1'b0;

    // Single write then read back
    wd[0] = 32'hAAAA_0000;
    write_burst(32'h10, 4'd3, 8'd0, 8'h01, lat, bid, bresp);
    check("single_b_latency", 32'(lat), 32'd1);
    check("single_bid",  32'(bid),   32'd3);
    check("single_bresp", 32'(bresp), 32'd0);
    read_burst(32'h10, 4'd5, 8'd0, lat, gaps);
    check("single_r_latency", 32'(lat), 32'(1 + RD_EXTRA));
    check("single_rdata", rd_data[0], 32'hAAAA_0000);
    check("single_rid",   32'(rd_id[0]), 32'd5);
    check("single_rlast", 32'(rd_last[0]), 32'd1);
    check("single_rresp", 32'(rd_resp[0]), 32'd0);

    // Four-beat burst
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    write_burst(32'h100, 4'd1, 8'd3, 8'h08, lat, bid, bresp);
    check("burst_bresp", 32'(bresp), 32'd0);
    read_burst(32'h100, 4'd2, 8'd3, lat, gaps);
    check("burst_gaps", 32'(gaps), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_rdata%0d", i), rd_data[i], 32'(i + 1));
      check($sformatf("burst_rlast%0d", i), 32'(rd_last[i]), (i == 3) ? 32'd1 : 32'd0);
    end

    // Read backpressure on a two-beat read
    wd[0] = 32'h11; wd[1] = 32'h22;
    write_burst(32'h200, 4'd0, 8'd1, 8'h02, lat, bid, bresp);
    send_ar(32'h200, 4'd7, 8'd1);
    wait_r(lat);
    check("bp_b0_rdata", RDATA, 32'h11);
    tick();
    check("bp_b0_hold_valid", 32'(RVALID), 32'd1);
    check("bp_b0_hold_rdata", RDATA, 32'h11);
    check("bp_b0_hold_rid", 32'(RID), 32'd7);
    check("bp_b0_hold_rlast", 32'(RLAST), 32'd0);
    RREADY = 1'b1; tick(); RREADY = 1'b0;
    check("bp_b1_rdata", RDATA, 32'h22);
    tick();
    check("bp_b1_hold_valid", 32'(RVALID), 32'd1);
    check("bp_b1_hold_rdata", RDATA, 32'h22);
    check("bp_b1_hold_rlast", 32'(RLAST), 32'd1);
    RREADY = 1'b1; tick(); RREADY = 1'b0;
    check("bp_done_rvalid", 32'(RVALID), 32'd0);
    check("bp_done_arready", 32'(ARREADY), 32'd1);

    // Write response backpressure; a new AW must wait
    send_aw(32'h300, 4'd9, 8'd0);
    send_w(32'h33, 1'b1);
    wait_b(lat);
    AWADDR = 32'h304; AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bhold_bvalid", 32'(BVALID), 32'd1);
      check("bhold_bid", 32'(BID), 32'd9);
      check("bhold_bresp", 32'(BRESP), 32'd0);
      check("bhold_awready", 32'(AWREADY), 32'd0);
      tick();
    end
    AWVALID = 1'b0;
    BREADY = 1'b1; tick(); BREADY = 1'b0;
    check("bhold_done_bvalid", 32'(BVALID), 32'd0);

    // Out of range write leaves aliased word untouched
    wd[0] = 32'h5A5A;
    write_burst(32'h0, 4'd0, 8'd0, 8'h01, lat, bid, bresp);
    wd[0] = 32'hDEAD;
    write_burst(32'h1000, 4'd4, 8'd0, 8'h01, lat, bid, bresp);
    check("oor_w_bresp", 32'(bresp), 32'd2);
    read_burst(32'h0, 4'd0, 8'd0, lat, gaps);
    check("oor_w_mem_unchanged", rd_data[0], 32'h5A5A);
    wd[0] = 32'h77;
    write_burst(32'hFFC, 4'd0, 8'd0, 8'h01, lat, bid, bresp);
    read_burst(32'hFFC, 4'd6, 8'd1, lat, gaps);
    check("oor_r_b0_data", rd_data[0], 32'h77);
    check("oor_r_b0_resp", 32'(rd_resp[0]), 32'd0);
    check("oor_r_b1_data", rd_data[1], 32'd0);
    check("oor_r_b1_resp", 32'(rd_resp[1]), 32'd2);
    check("oor_r_b1_last", 32'(rd_last[1]), 32'd1);

    // Early WLAST: both beats still taken, SLVERR reported
    wd[0] = 32'hC0; wd[1] = 32'hC1;
    write_burst(32'h40, 4'd8, 8'd1, 8'h01, lat, bid, bresp);
    check("wlast_bresp", 32'(bresp), 32'd2);
    check("wlast_bid", 32'(bid), 32'd8);
    read_burst(32'h40, 4'd0, 8'd1, lat, gaps);
    check("wlast_mem1", rd_data[1], 32'hC1);

    // Same-word write and read in flight together
    wd[0] = 32'h1111;
    write_burst(32'h20, 4'd0, 8'd0, 8'h01, lat, bid, bresp);
    AWADDR = 32'h20; AWID = 4'd2; AWLEN = 8'd0; AWVALID = 1'b1;
    ARADDR = 32'h20; ARID = 4'd3; ARLEN = 8'd0; ARVALID = 1'b1;
    check("conc_both_ready", {30'd0, AWREADY, ARREADY}, 32'd3);
    tick();
    AWVALID = 1'b0; ARVALID = 1'b0;
    WDATA = 32'h2222; WLAST = 1'b1; WVALID = 1'b1;
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
    wait_r(lat);
    check("conc_rdata", RDATA, RBW_EXP);
    check("conc_rid", 32'(RID), 32'd3);
    RREADY = 1'b1; tick(); RREADY = 1'b0;
    wait_b(lat);
    check("conc_bresp", {30'd0, BRESP} | {31'd0, ~BVALID}, 32'd0);
    BREADY = 1'b1; tick(); BREADY = 1'b0;
    read_burst(32'h20, 4'd0, 8'd0, lat, gaps);
    check("conc_new_value", rd_data[0], 32'h2222);

    // Reset during beat 2 of an eight-beat read
    RREADY = 1'b1;
    send_ar(32'h0, 4'd2, 8'd7);
    wait_r(lat);
    tick(); tick();
    check("mid_pre_rvalid", 32'(RVALID), 32'd1);
    check("mid_pre_rlast", 32'(RLAST), 32'd0);
    #2 ARESET = 1'b1;
    #1;
    check("mid_rvalid_async", 32'(RVALID), 32'd0);
    check("mid_arready_async", 32'(ARREADY), 32'd0);
    tick(); tick();
    ARESET = 1'b0;
    check("mid_arready_before_edge", 32'(ARREADY), 32'd0);
    tick();
    check("mid_arready_after_edge", 32'(ARREADY), 32'd1);
    tick(); tick();
    check("mid_no_r_after_abort", 32'(RVALID), 32'd0);
    check("mid_no_b_after_abort", 32'(BVALID), 32'd0);
    RREADY = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
